mem_model: RTL

- Parametrised byte-addressable simulation/FPGA memory model with independent read and write ports, each using a req/done handshake.
- Next generation of the core's fake memory. Adds configurable depth, data width and per-port latency, plus zero-extended reads, error reporting and a post-reset clearing sweep.
- Sits behind the fetch and load/store units as instruction/data backing store.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_port_ctrl.sv | 103 ++++++++++
 rtl/mem_model.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressable memory model: access size
// constants, the per-port state encoding and the access-size legality check.
package mem_pkg;

    localparam logic [2:0] SZ_BYTE = 3'd1;
    localparam logic [2:0] SZ_HALF = 3'd2;
    localparam logic [2:0] SZ_WORD = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } port_state_t;

    // An access size is legal when it is 1, 2 or 4 bytes and fits in one port word.
    function automatic logic size_legal(input logic [2:0] bytes, input int data_bytes);
        logic is_std;
        is_std = (bytes == SZ_BYTE) || (bytes == SZ_HALF) || (bytes == SZ_WORD);
        return is_std && (int'({29'd0, bytes}) <= data_bytes);
    endfunction

endpackage

// File: rtl/mem_port_ctrl.sv
// Request/latency controller for one memory port. Accepts a request when
// idle and the memory is ready, latches the request and its error check,
// counts out the configured latency and pulses done for one cycle.
module mem_port_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DATA_BYTES = 4,
    parameter int DEPTH      = 1024,
    parameter int LAT        = 1,
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        bytes,
    input  logic [DATA_W-1:0] data,
    output logic              complete,
    output logic [IDX_W-1:0]  idx_q,
    output logic [2:0]        bytes_q,
    output logic [DATA_W-1:0] data_q,
    output logic              chk_err_q,
    output logic              done,
    output logic              err
);
    import mem_pkg::*;

    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LAT - 1);
    localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W + 1)'(DEPTH);

    port_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             accept;
    logic             done_reg, err_reg;
    logic [ADDR_W:0]  end_addr;
    logic             req_err;

    // One extra bit so an access near the top of the address space cannot wrap into range.
    assign end_addr = {1'b0, addr} + (ADDR_W + 1)'(bytes);
    assign req_err  = !size_legal(bytes, DATA_BYTES) || (end_addr > LIMIT);

    // Next-state logic: accept on en&ready, count down, complete at zero.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en && ready) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counter and the registered completion pulse with its error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= complete;
            err_reg   <= complete & chk_err_q;
        end
    end

    // Capture the request at the accept edge so the requester may change its inputs afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            bytes_q   <= '0;
            data_q    <= '0;
            chk_err_q <= 1'b0;
        end else if (accept) begin
            idx_q     <= addr[IDX_W-1:0];
            bytes_q   <= bytes;
            data_q    <= data;
            chk_err_q <= req_err;
        end
    end

    assign done = done_reg;
    assign err  = err_reg;

endmodule

// File: rtl/mem_model.sv
// Byte-addressable memory model with independent read and write ports.
// Memory is zeroed one word per clock after reset; ports are only served
// once the sweep is complete. Reads sample and writes commit at completion.
module mem_model #(
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 4,
    parameter int DEPTH      = 1024,
    parameter int RD_LAT     = 1,
    parameter int WR_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic [2:0]              rd_bytes,
    output logic [8*DATA_BYTES-1:0] rd_data,
    output logic                    rd_done,
    output logic                    rd_err,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [2:0]              wr_bytes,
    input  logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    wr_done,
    output logic                    wr_err
);
    import mem_pkg::*;

    localparam int DW     = 8 * DATA_BYTES;
    localparam int WORDS  = DEPTH / DATA_BYTES;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LANE_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 0;
    localparam int PTR_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [7:0]       mem [DEPTH];
    logic             ready_reg;
    logic [PTR_W-1:0] sweep_ptr_reg;
    logic [IDX_W-1:0] sweep_base;

    logic             rd_complete, rd_chk_err;
    logic [IDX_W-1:0] rd_idx_q;
    logic [2:0]       rd_bytes_q;
    logic [DW-1:0]    rd_data_unused;
    logic [31:0]      rd_n_bytes;
    logic [DW-1:0]    rd_word;
    logic [DW-1:0]    rd_data_reg;

    logic             wr_complete, wr_chk_err;
    logic [IDX_W-1:0] wr_idx_q;
    logic [2:0]       wr_bytes_q;
    logic [DW-1:0]    wr_data_q;
    logic [31:0]      wr_n_bytes;

    mem_port_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DW), .DATA_BYTES(DATA_BYTES), .DEPTH(DEPTH), .LAT(RD_LAT)
    ) u_rd_port (
        .clk(clk), .rst(rst), .ready(ready_reg),
        .en(rd_en), .addr(rd_addr), .bytes(rd_bytes), .data('0),
        .complete(rd_complete), .idx_q(rd_idx_q), .bytes_q(rd_bytes_q),
        .data_q(rd_data_unused), .chk_err_q(rd_chk_err),
        .done(rd_done), .err(rd_err)
    );

    mem_port_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DW), .DATA_BYTES(DATA_BYTES), .DEPTH(DEPTH), .LAT(WR_LAT)
    ) u_wr_port (
        .clk(clk), .rst(rst), .ready(ready_reg),
        .en(wr_en), .addr(wr_addr), .bytes(wr_bytes), .data(wr_data),
        .complete(wr_complete), .idx_q(wr_idx_q), .bytes_q(wr_bytes_q),
        .data_q(wr_data_q), .chk_err_q(wr_chk_err),
        .done(wr_done), .err(wr_err)
    );

    assign sweep_base = IDX_W'(sweep_ptr_reg) << LANE_W;
    assign rd_n_bytes = 32'(rd_bytes_q);
    assign wr_n_bytes = 32'(wr_bytes_q);

    // Clear sweep: advance one word per clock; ready rises with the last word's clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_reg     <= 1'b0;
            sweep_ptr_reg <= '0;
        end else if (!ready_reg) begin
            if (sweep_ptr_reg == PTR_W'(WORDS - 1)) begin
                ready_reg <= 1'b1;
            end else begin
                sweep_ptr_reg <= sweep_ptr_reg + 1'b1;
            end
        end
    end

    // Byte array writes: zero a word during the sweep, otherwise commit a completed write.
    always_ff @(posedge clk) begin
        if (!ready_reg) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                mem[sweep_base + IDX_W'(b)] <= 8'h00;
            end
        end else if (wr_complete && !wr_chk_err) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (32'(b) < wr_n_bytes) begin
                    mem[wr_idx_q + IDX_W'(b)] <= wr_data_q[8*b +: 8];
                end
            end
        end
    end

    // Gather the requested bytes little-endian into the low lanes, zeros above.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BYTES; gi++) begin : g_rd_lane
            localparam logic [31:0] LANE = 32'(gi);
            assign rd_word[8*gi +: 8] = (LANE < rd_n_bytes) ? mem[rd_idx_q + IDX_W'(gi)] : 8'h00;
        end
    endgenerate

    // Read data register: updated only at read completion, zero on error, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_complete) begin
            rd_data_reg <= rd_chk_err ? '0 : rd_word;
        end
    end

    assign ready   = ready_reg;
    assign rd_data = rd_data_reg;

endmodule
